// File: rtl/ofs_plat_utils_ccip_active_credit_tracker.sv
// ----------------------------------------------------------------------------
// ccip_if_pkg (minimal subset)
//   CCI-P channel structures and response encodings needed by the active
//   credit tracker: request/response valids, request line length, response
//   type, packed-write format and cl_num.
//
// ofs_plat_utils_ccip_active_credit_tracker
//   Tracks the number of cache lines in flight on the CCI-P read (c0) and
//   write (c1) channels. Every cycle each channel's increment (new request
//   lines) and decrement (retired response lines) are netted into a signed
//   4-bit delta. The delta is registered in stage 1 and added to the
//   saturating counter in stage 2. A request presented in cycle N is
//   therefore visible on the count in cycle N+2.
//
//   Parameters:
//     C0_CNT_WIDTH, C1_CNT_WIDTH  counter widths (must be >= 3)
//     C0_MAX_ACTIVE, C1_MAX_ACTIVE credit limits in lines
//     ALMOST_FULL_SLACK           headroom below the limit for almost_full
//
//   Ports:
//     clk            single clock
//     reset_n        asynchronous active-low reset
//     c0Tx / c0Rx    read request / read response channels
//     c1Tx / c1Rx    write request / write response channels
//     hwm_clr        load both high-water marks with the current counts
//     err_clr        clear both sticky error flags
//     c0_cnt/c1_cnt  pending read / write lines
//     c0_almost_full, c1_almost_full  count >= limit - slack
//     c0_hwm/c1_hwm  high-water marks since the last clear
//     err_underflow  sticky: response retired more lines than were pending
//     err_overflow   sticky: count saturated at the counter maximum
//
//   Build option:
//     OFS_PLAT_CCIP_ACTIVE_CNT_HWM_EN  when defined, high-water mark
//     registers are built; otherwise c0_hwm/c1_hwm are constant zero and
//     hwm_clr is ignored.
// ----------------------------------------------------------------------------

package ccip_if_pkg;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef logic [1:0]  t_ccip_clLen;
  typedef logic [1:0]  t_ccip_clNum;
  typedef logic [15:0] t_ccip_mdata;

  typedef struct packed {
    t_ccip_clLen cl_len;
    t_ccip_mdata mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_clLen cl_len;
    t_ccip_mdata mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    logic         format;
    t_ccip_clNum  cl_num;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

module ofs_plat_utils_ccip_active_credit_tracker
  import ccip_if_pkg::*;
#(
  parameter int C0_CNT_WIDTH      = 10,
  parameter int C1_CNT_WIDTH      = 10,
  parameter int C0_MAX_ACTIVE     = 512,
  parameter int C1_MAX_ACTIVE     = 512,
  parameter int ALMOST_FULL_SLACK = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  t_if_ccip_c0_Tx          c0Tx,
  input  t_if_ccip_c0_Rx          c0Rx,
  input  t_if_ccip_c1_Tx          c1Tx,
  input  t_if_ccip_c1_Rx          c1Rx,

  input  logic                    hwm_clr,
  input  logic                    err_clr,

  output logic [C0_CNT_WIDTH-1:0] c0_cnt,
  output logic [C1_CNT_WIDTH-1:0] c1_cnt,
  output logic                    c0_almost_full,
  output logic                    c1_almost_full,
  output logic [C0_CNT_WIDTH-1:0] c0_hwm,
  output logic [C1_CNT_WIDTH-1:0] c1_hwm,
  output logic                    err_underflow,
  output logic                    err_overflow
);

  localparam int C0_AF_THRESH = C0_MAX_ACTIVE - ALMOST_FULL_SLACK;
  localparam int C1_AF_THRESH = C1_MAX_ACTIVE - ALMOST_FULL_SLACK;

  // --------------------------------------------------------------------------
  // Stage 1: per-channel increment/decrement netted into one signed delta.
  // c0 delta range is -1..+4, c1 delta range is -4..+1.
  // --------------------------------------------------------------------------
  logic [2:0]        c0_inc;
  logic              c0_dec;
  logic              c1_inc;
  logic [2:0]        c1_dec;
  logic signed [3:0] c0_delta_next;
  logic signed [3:0] c1_delta_next;
  logic signed [3:0] c0_delta_reg;
  logic signed [3:0] c1_delta_reg;

  assign c0_inc = c0Tx.valid ? (3'd1 + {1'b0, c0Tx.hdr.cl_len}) : 3'd0;
  assign c0_dec = c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE);

  // Every write beat counts as one line, write fences included.
  assign c1_inc = c1Tx.valid;

  // Only a packed write completion retires more than one line; all other
  // c1 responses (unpacked writes, fences, interrupts) retire exactly one.
  always_comb begin
    c1_dec = 3'd0;
    if (c1Rx.rspValid) begin
      if (c1Rx.hdr.format && (c1Rx.hdr.resp_type == eRSP_WRLINE)) begin
        c1_dec = 3'd1 + {1'b0, c1Rx.hdr.cl_num};
      end else begin
        c1_dec = 3'd1;
      end
    end
  end

  assign c0_delta_next = $signed({1'b0, c0_inc}) - $signed({3'b000, c0_dec});
  assign c1_delta_next = $signed({3'b000, c1_inc}) - $signed({1'b0, c1_dec});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_delta_reg <= '0;
      c1_delta_reg <= '0;
    end else begin
      c0_delta_reg <= c0_delta_next;
      c1_delta_reg <= c1_delta_next;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: saturating accumulate. The sum is computed two bits wider than
  // the counter so that both a negative result (MSB set) and a result above
  // the counter maximum (next bit set) are visible.
  // --------------------------------------------------------------------------
  logic [C0_CNT_WIDTH-1:0]        c0_cnt_reg;
  logic [C1_CNT_WIDTH-1:0]        c1_cnt_reg;
  logic [C0_CNT_WIDTH-1:0]        c0_cnt_next;
  logic [C1_CNT_WIDTH-1:0]        c1_cnt_next;
  logic signed [C0_CNT_WIDTH+1:0] c0_sum;
  logic signed [C1_CNT_WIDTH+1:0] c1_sum;
  logic                           c0_under;
  logic                           c0_over;
  logic                           c1_under;
  logic                           c1_over;

  assign c0_sum = $signed({2'b00, c0_cnt_reg}) +
                  $signed({{(C0_CNT_WIDTH-2){c0_delta_reg[3]}}, c0_delta_reg});
  assign c1_sum = $signed({2'b00, c1_cnt_reg}) +
                  $signed({{(C1_CNT_WIDTH-2){c1_delta_reg[3]}}, c1_delta_reg});

  assign c0_under = c0_sum[C0_CNT_WIDTH+1];
  assign c0_over  = ~c0_sum[C0_CNT_WIDTH+1] & c0_sum[C0_CNT_WIDTH];
  assign c1_under = c1_sum[C1_CNT_WIDTH+1];
  assign c1_over  = ~c1_sum[C1_CNT_WIDTH+1] & c1_sum[C1_CNT_WIDTH];

  always_comb begin
    c0_cnt_next = c0_sum[C0_CNT_WIDTH-1:0];
    if (c0_under) begin
      c0_cnt_next = '0;
    end else if (c0_over) begin
      c0_cnt_next = '1;
    end
  end

  always_comb begin
    c1_cnt_next = c1_sum[C1_CNT_WIDTH-1:0];
    if (c1_under) begin
      c1_cnt_next = '0;
    end else if (c1_over) begin
      c1_cnt_next = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_cnt_reg <= '0;
      c1_cnt_reg <= '0;
    end else begin
      c0_cnt_reg <= c0_cnt_next;
      c1_cnt_reg <= c1_cnt_next;
    end
  end

  assign c0_cnt = c0_cnt_reg;
  assign c1_cnt = c1_cnt_reg;

  // Decoded straight from the count register so it tracks the count with
  // no extra cycle of lag.
  assign c0_almost_full = (c0_cnt_reg >= C0_CNT_WIDTH'(C0_AF_THRESH));
  assign c1_almost_full = (c1_cnt_reg >= C1_CNT_WIDTH'(C1_AF_THRESH));

  // --------------------------------------------------------------------------
  // Sticky error flags. A new error in the same cycle as err_clr keeps the
  // flag set so that no event is lost across a clear.
  // --------------------------------------------------------------------------
  logic err_underflow_reg;
  logic err_overflow_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_underflow_reg <= 1'b0;
      err_overflow_reg  <= 1'b0;
    end else begin
      if (c0_under || c1_under) begin
        err_underflow_reg <= 1'b1;
      end else if (err_clr) begin
        err_underflow_reg <= 1'b0;
      end

      if (c0_over || c1_over) begin
        err_overflow_reg <= 1'b1;
      end else if (err_clr) begin
        err_overflow_reg <= 1'b0;
      end
    end
  end

  assign err_underflow = err_underflow_reg;
  assign err_overflow  = err_overflow_reg;

  // --------------------------------------------------------------------------
  // High-water marks. A mark follows the registered count one cycle later
  // whenever the count exceeds it; a clear reloads it with the current count
  // instead of zero so the mark is immediately meaningful again.
  // --------------------------------------------------------------------------
`ifdef OFS_PLAT_CCIP_ACTIVE_CNT_HWM_EN
  logic [C0_CNT_WIDTH-1:0] c0_hwm_reg;
  logic [C1_CNT_WIDTH-1:0] c1_hwm_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_hwm_reg <= '0;
      c1_hwm_reg <= '0;
    end else begin
      if (hwm_clr) begin
        c0_hwm_reg <= c0_cnt_reg;
      end else if (c0_cnt_reg > c0_hwm_reg) begin
        c0_hwm_reg <= c0_cnt_reg;
      end

      if (hwm_clr) begin
        c1_hwm_reg <= c1_cnt_reg;
      end else if (c1_cnt_reg > c1_hwm_reg) begin
        c1_hwm_reg <= c1_cnt_reg;
      end
    end
  end

  assign c0_hwm = c0_hwm_reg;
  assign c1_hwm = c1_hwm_reg;

  logic unused_inputs;
  assign unused_inputs = ^{c0Tx.hdr.mdata, c0Rx.hdr.mdata, c1Tx.hdr,
                           c1Rx.hdr.mdata};
`else
  assign c0_hwm = '0;
  assign c1_hwm = '0;

  logic unused_inputs;
  assign unused_inputs = ^{c0Tx.hdr.mdata, c0Rx.hdr.mdata, c1Tx.hdr,
                           c1Rx.hdr.mdata, hwm_clr};
`endif

endmodule

// File: tb/tb_ofs_plat_utils_ccip_active_credit_tracker.sv
// Scoreboard bench: stimulus drives one cycle at a time and pushes the
// hand-computed expected outputs (tagged with the cycle in which they must
// be visible) into a queue; an independent monitor pops and compares.
module tb_ofs_plat_utils_ccip_active_credit_tracker;
  import ccip_if_pkg::*;

  localparam int X = -1;  // field not checked

`ifdef OFS_PLAT_CCIP_ACTIVE_CNT_HWM_EN
  localparam int HWM_PEAK  = 37;
  localparam int HWM_CLR   = 5;
  localparam int HWM_C0CLR = 1;
`else
  localparam int HWM_PEAK  = 0;
  localparam int HWM_CLR   = 0;
  localparam int HWM_C0CLR = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  t_if_ccip_c0_Tx c0Tx;
  t_if_ccip_c0_Rx c0Rx;
  t_if_ccip_c1_Tx c1Tx;
  t_if_ccip_c1_Rx c1Rx;
  logic hwm_clr;
  logic err_clr;
  logic [9:0] c0_cnt, c1_cnt, c0_hwm, c1_hwm;
  logic c0_almost_full, c1_almost_full, err_underflow, err_overflow;

  always #5 clk = ~clk;

  ofs_plat_utils_ccip_active_credit_tracker dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .c0Tx           (c0Tx),
    .c0Rx           (c0Rx),
    .c1Tx           (c1Tx),
    .c1Rx           (c1Rx),
    .hwm_clr        (hwm_clr),
    .err_clr        (err_clr),
    .c0_cnt         (c0_cnt),
    .c1_cnt         (c1_cnt),
    .c0_almost_full (c0_almost_full),
    .c1_almost_full (c1_almost_full),
    .c0_hwm         (c0_hwm),
    .c1_hwm         (c1_hwm),
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow)
  );

  typedef struct {
    int    cyc;
    string name;
    int    c0, c1, af0, af1, uf, of, h0, h1;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  function automatic void chk(string name, string field, int act, int exp);
    if (exp < 0) return;
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d (cycle %0d)", name, field, act, exp, cyc);
    end
  endfunction

  function automatic void chk_all(exp_t e);
    chk(e.name, "c0_cnt", int'(c0_cnt), e.c0);
    chk(e.name, "c1_cnt", int'(c1_cnt), e.c1);
    chk(e.name, "c0_af", int'(c0_almost_full), e.af0);
    chk(e.name, "c1_af", int'(c1_almost_full), e.af1);
    chk(e.name, "err_uf", int'(err_underflow), e.uf);
    chk(e.name, "err_of", int'(err_overflow), e.of);
    chk(e.name, "c0_hwm", int'(c0_hwm), e.h0);
    chk(e.name, "c1_hwm", int'(c1_hwm), e.h1);
    $display("cycle %0d %s: c0=%0d c1=%0d af=%0d/%0d uf=%0d of=%0d hwm=%0d/%0d",
             cyc, e.name, c0_cnt, c1_cnt, c0_almost_full, c1_almost_full,
             err_underflow, err_overflow, c0_hwm, c1_hwm);
  endfunction

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s.missed: got cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
        end else begin
          chk_all(e);
        end
      end
    end
  end

  task automatic drive(bit c0v, int len, bit c0r, bit c1v, bit c1r,
                       bit fmt, int num, bit hclr, bit eclr);
    logic [1:0] l2, n2;
    l2 = len[1:0];
    n2 = num[1:0];
    @(negedge clk);
    c0Tx = '0; c0Rx = '0; c1Tx = '0; c1Rx = '0;
    c0Tx.valid = c0v;
    c0Tx.hdr.cl_len = l2;
    c0Rx.rspValid = c0r;
    c0Rx.hdr.resp_type = eRSP_RDLINE;
    c1Tx.valid = c1v;
    c1Rx.rspValid = c1r;
    c1Rx.hdr.resp_type = eRSP_WRLINE;
    c1Rx.hdr.format = fmt;
    c1Rx.hdr.cl_num = n2;
    hwm_clr = hclr;
    err_clr = eclr;
  endtask

  task automatic tx0(int len);        drive(1, len, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic rx0();               drive(0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic tx1();               drive(0, 0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic rx1(bit f, int n);   drive(0, 0, 0, 0, 1, f, n, 0, 0); endtask
  task automatic idle();              drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic eclr();              drive(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic hclr();              drive(0, 0, 0, 0, 0, 0, 0, 1, 0); endtask

  task automatic expect_in(int k, string name, int c0, int c1, int af0, int af1,
                           int uf, int of, int h0, int h1);
    exp_t e;
    e.cyc = cyc + k; e.name = name;
    e.c0 = c0; e.c1 = c1; e.af0 = af0; e.af1 = af1;
    e.uf = uf; e.of = of; e.h0 = h0; e.h1 = h1;
    sb.push_back(e);
  endtask

  task automatic check_now(string name);
    exp_t e;
    e.cyc = cyc; e.name = name;
    e.c0 = 0; e.c1 = 0; e.af0 = 0; e.af1 = 0;
    e.uf = 0; e.of = 0; e.h0 = 0; e.h1 = 0;
    chk_all(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    c0Tx = '0; c0Rx = '0; c1Tx = '0; c1Rx = '0;
    hwm_clr = 1'b0; err_clr = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_now("reset_state");
    reset_n = 1'b1;

    // Multi-line read then four single-line completions.
    tx0(3); expect_in(2, "c0_rd_len4", 4, 0, 0, 0, 0, 0, X, X);
    rx0();  expect_in(2, "c0_rsp1", 3, 0, 0, 0, 0, 0, X, X);
    rx0();  expect_in(2, "c0_rsp2", 2, 0, 0, 0, 0, 0, X, X);
    rx0();  expect_in(2, "c0_rsp3", 1, 0, 0, 0, 0, 0, X, X);
    rx0();  expect_in(2, "c0_rsp4", 0, 0, 0, 0, 0, 0, X, X);

    // Four write beats, one packed completion retiring all four.
    tx1(); expect_in(2, "c1_beat1", 0, 1, 0, 0, 0, 0, X, X);
    tx1(); expect_in(2, "c1_beat2", 0, 2, 0, 0, 0, 0, X, X);
    tx1(); expect_in(2, "c1_beat3", 0, 3, 0, 0, 0, 0, X, X);
    tx1(); expect_in(2, "c1_beat4", 0, 4, 0, 0, 0, 0, X, X);
    rx1(1, 3); expect_in(2, "c1_packed", 0, 0, 0, 0, 0, 0, X, X);

    // Same-cycle request and response net; unpacked response ignores cl_num.
    drive(1, 1, 1, 1, 1, 0, 3, 0, 0);
    expect_in(2, "net_same_cycle", 1, 0, 0, 0, 0, 0, X, X);
    rx0(); expect_in(2, "c0_drain", 0, 0, 0, 0, 0, 0, X, X);

    // Underflow on c0, sticky, then cleared.
    rx0();  expect_in(2, "c0_underflow", 0, 0, 0, 0, 1, 0, X, X);
    idle(); expect_in(1, "uf_sticky", 0, 0, 0, 0, 1, 0, X, X);
    eclr(); expect_in(1, "uf_cleared", 0, 0, 0, 0, 0, 0, X, X);

    // Underflow on c1 colliding with err_clr: new error wins.
    rx1(0, 0);
    eclr(); expect_in(1, "uf_beats_clr", 0, 0, 0, 0, 1, 0, X, X);
    idle(); expect_in(1, "uf_after_clr", 0, 0, 0, 0, 1, 0, X, X);
    eclr(); expect_in(1, "uf_cleared2", 0, 0, 0, 0, 0, 0, X, X);

    // Almost-full boundary at 512-8 = 504.
    repeat (125) tx0(3);
    tx0(2); expect_in(2, "c0_503", 503, 0, 0, 0, 0, 0, X, X);
    tx0(0); expect_in(2, "c0_504_af", 504, 0, 1, 0, 0, 0, X, X);
    rx0();  expect_in(2, "c0_503_again", 503, 0, 0, 0, 0, 0, X, X);
    tx0(0); expect_in(2, "c0_504_af2", 504, 0, 1, 0, 0, 0, X, X);

    // Overflow: 504 + 129*4 + 3 = 1023 exactly, then one more line.
    repeat (129) tx0(3);
    tx0(2); expect_in(2, "c0_max", 1023, 0, 1, 0, 0, 0, X, X);
    tx0(0); expect_in(2, "c0_overflow", 1023, 0, 1, 0, 0, 1, X, X);
    idle();
    idle(); expect_in(1, "of_sticky", 1023, 0, 1, 0, 0, 1, X, X);
    eclr(); expect_in(1, "of_cleared", 1023, 0, 1, 0, 0, 0, X, X);

    // Clean reset, build to 20, then reset with a delta in flight.
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (4) tx0(3);
    tx0(3); expect_in(2, "c0_20", 20, 0, 0, 0, 0, 0, X, X);
    tx0(3);
    @(negedge clk);
    c0Tx = '0;
    reset_n = 1'b0;
    #1;
    check_now("async_reset");
    @(negedge clk); reset_n = 1'b1;
    idle();  expect_in(2, "post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    tx0(0);  expect_in(2, "first_after_reset", 1, 0, 0, 0, 0, 0, X, X);

    // High-water mark: c1 to 37, down to 5, then clear.
    repeat (36) tx1();
    tx1(); expect_in(2, "c1_37", 1, 37, 0, 0, 0, 0, X, X);
    rx1(1, 3); expect_in(2, "c1_33_hwm", 1, 33, 0, 0, 0, 0, X, HWM_PEAK);
    repeat (6) rx1(1, 3);
    rx1(1, 3); expect_in(2, "c1_5_hwm", 1, 5, 0, 0, 0, 0, X, HWM_PEAK);
    idle();
    hclr(); expect_in(1, "hwm_clr", 1, 5, 0, 0, 0, 0, HWM_C0CLR, HWM_CLR);
    idle(); expect_in(2, "hwm_hold", 1, 5, 0, 0, 0, 0, HWM_C0CLR, HWM_CLR);

    repeat (4) idle();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofs_plat_utils_ccip_active_credit_tracker.md
OFS_PLAT_UTILS_CCIP_ACTIVE_CREDIT_TRACKER -- requirements
Module: ofs_plat_utils_ccip_active_credit_tracker

Interface
REQ-001 Parameter C0_CNT_WIDTH, default 10: width of the c0 pending-line counter.
REQ-002 Parameter C1_CNT_WIDTH, default 10: width of the c1 pending-line counter.
REQ-003 Parameter C0_MAX_ACTIVE, default 512: c0 credit limit in lines; SHALL be at most 2^C0_CNT_WIDTH-1.
REQ-004 Parameter C1_MAX_ACTIVE, default 512: c1 credit limit in lines; SHALL be at most 2^C1_CNT_WIDTH-1.
REQ-005 Parameter ALMOST_FULL_SLACK, default 8: headroom in lines below the limit; SHALL be less than both limits.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port c0Tx, input, t_if_ccip_c0_Tx: read request channel.
REQ-009 Port c0Rx, input, t_if_ccip_c0_Rx: read response channel.
REQ-010 Port c1Tx, input, t_if_ccip_c1_Tx: write request channel.
REQ-011 Port c1Rx, input, t_if_ccip_c1_Rx: write response channel.
REQ-012 Port hwm_clr, input, 1 bit: synchronous clear of both high-water marks.
REQ-013 Port err_clr, input, 1 bit: synchronous clear of both sticky error flags.
REQ-014 Port c0_cnt, output, C0_CNT_WIDTH: pending read lines.
REQ-015 Port c1_cnt, output, C1_CNT_WIDTH: pending write lines.
REQ-016 Port c0_almost_full, output, 1 bit: asserted when c0_cnt >= C0_MAX_ACTIVE-ALMOST_FULL_SLACK.
REQ-017 Port c1_almost_full, output, 1 bit: asserted when c1_cnt >= C1_MAX_ACTIVE-ALMOST_FULL_SLACK.
REQ-018 Port c0_hwm, output, C0_CNT_WIDTH: maximum c0_cnt since the last clear.
REQ-019 Port c1_hwm, output, C1_CNT_WIDTH: maximum c1_cnt since the last clear.
REQ-020 Port err_underflow, output, 1 bit: sticky flag for a response with no matching pending line.
REQ-021 Port err_overflow, output, 1 bit: sticky flag for a count exceeding its counter width.

Function
REQ-022 c0 increment SHALL be 1+cl_len when c0Tx.valid is asserted, else 0 (range 0..4).
REQ-023 c0 decrement SHALL be 1 when c0Rx.rspValid is asserted and resp_type==eRSP_RDLINE, else 0.
REQ-024 c1 increment SHALL be 1 per c1Tx.valid beat, including write fences.
REQ-025 c1 decrement SHALL be 1+cl_num for a packed (format=1) eRSP_WRLINE response, 1 for any other c1Rx.rspValid, else 0.
REQ-026 Each channel SHALL register a signed 4-bit delta (increment minus decrement) in stage 1 and add it to the counter in stage 2.
REQ-027 Counter latency SHALL be exactly 2 cycles: an event sampled at edge N is reflected in the count at edge N+2.
REQ-028 A simultaneous request and response in the same cycle SHALL net into a single delta.
REQ-029 If the sum would fall below 0, the counter SHALL saturate to 0 and err_underflow SHALL set.
REQ-030 If the sum would exceed 2^W-1, the counter SHALL saturate to 2^W-1 and err_overflow SHALL set.
REQ-031 c*_almost_full SHALL be decoded from the registered counter, adding no further latency.
REQ-032 Each high-water mark SHALL update to its counter value on the cycle after the counter exceeds the current mark.
REQ-033 hwm_clr SHALL load each mark with the current counter value; clear SHALL take priority over update.
REQ-034 err_clr SHALL clear both error flags; a new error in the same cycle SHALL win and leave the flag set.

Reset
REQ-035 Assertion of reset_n SHALL asynchronously zero the deltas, counters, marks and error flags, and deassert both almost_full outputs.
REQ-036 Reset asserted mid-traffic SHALL discard in-flight deltas; the first event after release SHALL be counted per REQ-027.

Configuration
REQ-037 With macro OFS_PLAT_CCIP_ACTIVE_CNT_HWM_EN defined, high-water tracking per REQ-032/033 SHALL be built.
REQ-038 Without OFS_PLAT_CCIP_ACTIVE_CNT_HWM_EN, c0_hwm and c1_hwm SHALL be tied to 0, hwm_clr SHALL be ignored and no mark registers SHALL exist.

Verification
REQ-039 Scenario: 1 c0Tx with cl_len=3 at cycle 0 -> c0_cnt=4 at cycle 2; 4 eRSP_RDLINE responses -> c0_cnt=0.
REQ-040 Scenario: 4 c1Tx beats, then one packed WRLINE with cl_num=3 -> c1_cnt peaks at 4, then returns to 0, with no error.
REQ-041 Scenario: c0_cnt=0 and one eRSP_RDLINE -> c0_cnt stays 0 and err_underflow=1; err_clr -> 0.
REQ-042 Scenario: limit 512, slack 8, drive c0_cnt to 503 -> almost_full=0; at 504 -> almost_full=1.
REQ-043 Scenario (HWM_EN): c1_cnt rises to 37, then falls to 5 -> c1_hwm=37; hwm_clr -> c1_hwm=5.
REQ-044 Scenario: reset_n dropped with c0_cnt=20 and a pending delta -> all outputs 0 immediately, still 0 two cycles after release.
